// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if
//   Handshake between the request arbiter and the DMA timing control.
//   master (arbiter side):        drives valid_dreq, active_chan, busy
//                                 samples valid_dack, xfer_done, EOP_N
//   slave  (timing control side): the mirror image
interface dma_priority_arbiter_if #(parameter int NCH = 4);
  logic [NCH-1:0] valid_dreq;   // one-hot granted channel
  logic [1:0]     active_chan;  // channel being serviced
  logic           busy;         // arbiter not IDLE
  logic           valid_dack;   // timing control in transfer window
  logic           xfer_done;    // one transfer completed (pulse)
  logic           EOP_N;        // end of process, active low

  modport master (
    output valid_dreq, active_chan, busy,
    input  valid_dack, xfer_done, EOP_N
  );

  modport slave (
    input  valid_dreq, active_chan, busy,
    output valid_dack, xfer_done, EOP_N
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Synchronises DREQ, merges software requests, resolves fixed or rotating
//   priority and holds a one-hot grant toward the timing control for the
//   duration dictated by the channel mode. Drives polarity-corrected DACK and
//   pulses req_clr / mask_set when a service ends.
// Ports:
//   CLK, RESET_N      clock, async active-low reset
//   DREQ              asynchronous peripheral requests
//   HLDA              CPU hold acknowledge (DACK source in cascade mode)
//   command_reg       [2] disable, [4] rotate, [6] DREQ low, [7] DACK high
//   mode_reg          6 bits per channel: [5:4] mode, [2] autoinit
//   mask_reg, req_reg channel masks, software requests
//   tc                handshake with the timing control (master modport)
//   DACK              acknowledge pins
//   req_clr, mask_set one-cycle completion pulses
module dma_priority_arbiter #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NCH-1:0]       DREQ,
  input  logic                 HLDA,
  input  logic [7:0]           command_reg,
  input  logic [6*NCH-1:0]     mode_reg,
  input  logic [NCH-1:0]       mask_reg,
  input  logic [NCH-1:0]       req_reg,
  dma_priority_arbiter_if.master tc,
  output logic [NCH-1:0]       DACK,
  output logic [NCH-1:0]       req_clr,
  output logic [NCH-1:0]       mask_set
);

  localparam logic [1:0] M_DEMAND  = 2'd0;
  localparam logic [1:0] M_SINGLE  = 2'd1;
  localparam logic [1:0] M_BLOCK   = 2'd2;
  localparam logic [1:0] M_CASCADE = 2'd3;
  localparam logic [NCH-1:0] ONE   = {{(NCH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARB, GRANT, RELEASE} state_t;

  state_t                         state_q;
  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [1:0]                     ptr_q, chan_q, mode_q;
  logic                           autoinit_q;
  logic [NCH-1:0]                 vdreq_q, dack_q, req_clr_q, mask_set_q;

  logic [NCH-1:0] hw, raw_req, pend, chan_oh;
  logic [1:0]     base, idx, win;
  logic [5:0]     win_field;
  logic           exit_eop, grant_exit, dack_on;

  assign hw      = sync_q[SYNC_STAGES-1] ^ {NCH{command_reg[6]}};
  assign raw_req = hw | req_reg;
  assign pend    = command_reg[2] ? '0 : (raw_req & ~mask_reg);
  assign chan_oh = ONE << chan_q;

  // Walk from the lowest-priority slot up so the highest-priority pending
  // channel is the last one written.
  always_comb begin
    win  = '0;
    idx  = '0;
    base = command_reg[4] ? ptr_q : 2'd0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = base + 2'(k);
      if (pend[idx]) win = idx;
    end
  end

  assign win_field = mode_reg[6*win +: 6];

  // EOP wins over every other exit; a mask raised mid-service is honoured at
  // the next completed transfer. Cascade ignores both.
  always_comb begin
    exit_eop   = !tc.EOP_N && (mode_q != M_CASCADE);
    grant_exit = 1'b0;
    if (exit_eop)
      grant_exit = 1'b1;
    else if (mode_q != M_CASCADE && tc.xfer_done && mask_reg[chan_q])
      grant_exit = 1'b1;
    else begin
      case (mode_q)
        M_SINGLE:  grant_exit = tc.xfer_done;
        M_DEMAND:  grant_exit = tc.xfer_done && !raw_req[chan_q];
        M_BLOCK:   grant_exit = 1'b0;
        M_CASCADE: grant_exit = !raw_req[chan_q];
        default:   grant_exit = 1'b0;
      endcase
    end
  end

  assign dack_on = (state_q == GRANT) &&
                   ((mode_q == M_CASCADE) ? HLDA : tc.valid_dack);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      ptr_q      <= '0;
      chan_q     <= '0;
      mode_q     <= '0;
      autoinit_q <= 1'b0;
      vdreq_q    <= '0;
      dack_q     <= '1;
      req_clr_q  <= '0;
      mask_set_q <= '0;
    end else begin
      sync_q[0] <= DREQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      req_clr_q  <= '0;
      mask_set_q <= '0;
      // Inactive level everywhere, flipped on the serviced channel.
      dack_q <= {NCH{~command_reg[7]}} ^ (dack_on ? chan_oh : '0);
      case (state_q)
        IDLE: if (|pend) state_q <= ARB;
        ARB: begin
          if (|pend) begin
            chan_q     <= win;
            mode_q     <= win_field[5:4];
            autoinit_q <= win_field[2];
            vdreq_q    <= ONE << win;
            state_q    <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            vdreq_q <= '0;
            ptr_q   <= chan_q + 2'd1;
            if (req_reg[chan_q])          req_clr_q  <= chan_oh;
            if (exit_eop && !autoinit_q)  mask_set_q <= chan_oh;
            state_q <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tc.valid_dreq  = vdreq_q;
  assign tc.active_chan = chan_q;
  assign tc.busy        = (state_q != IDLE);
  assign DACK           = dack_q;
  assign req_clr        = req_clr_q;
  assign mask_set       = mask_set_q;

  logic unused_bits;
  assign unused_bits = ^{command_reg[5], command_reg[3], command_reg[1:0],
                         win_field[3], win_field[1:0]};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  DREQ;
  logic        HLDA;
  logic [7:0]  command_reg;
  logic [23:0] mode_reg;
  logic [3:0]  mask_reg, req_reg;
  logic [3:0]  DACK, req_clr, mask_set;
  int          tests_run = 0;
  int          fails = 0;

  localparam logic [23:0] ALL_SINGLE = {4{6'b010000}};
  localparam logic [23:0] CH2_BLOCK  = {6'b010000, 6'b100000, 6'b010000, 6'b010000};

  dma_priority_arbiter_if tcif ();

  dma_priority_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA),
    .command_reg(command_reg), .mode_reg(mode_reg), .mask_reg(mask_reg),
    .req_reg(req_reg), .tc(tcif), .DACK(DACK), .req_clr(req_clr),
    .mask_set(mask_set)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 12 && tcif.valid_dreq == 4'b0; n++) step();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 12 && tcif.busy; n++) step();
  endtask

  task automatic xfer_window();
    tcif.valid_dack = 1'b1; step();
  endtask

  task automatic xfer_finish();
    tcif.valid_dack = 1'b0; tcif.xfer_done = 1'b1; step();
    tcif.xfer_done = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; DREQ = 4'b0; HLDA = 1'b0; command_reg = 8'h00;
    mode_reg = ALL_SINGLE; mask_reg = 4'b0; req_reg = 4'b0;
    tcif.valid_dack = 1'b0; tcif.xfer_done = 1'b0; tcif.EOP_N = 1'b1;
    step(); step(); RESET_N = 1'b1; step();
    tests_run++; if (tcif.valid_dreq !== 4'b0) begin fails++; $display("FAIL reset_vdreq got %b want 0000", tcif.valid_dreq); end
    tests_run++; if (DACK !== 4'b1111) begin fails++; $display("FAIL reset_dack got %b want 1111", DACK); end
    tests_run++; if (tcif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", tcif.busy); end
    tests_run++; if (tcif.active_chan !== 2'd0) begin fails++; $display("FAIL reset_chan got %0d want 0", tcif.active_chan); end
    tests_run++; if ({req_clr, mask_set} !== 8'b0) begin fails++; $display("FAIL reset_pulses got %b want 0", {req_clr, mask_set}); end
  endtask

  task automatic test_fixed();
    DREQ = 4'b1010;
    wait_grant();
    DREQ = 4'b1000;
    tests_run++; if (tcif.valid_dreq !== 4'b0010) begin fails++; $display("FAIL fixed_first got %b want 0010", tcif.valid_dreq); end
    tests_run++; if (DACK !== 4'b1111) begin fails++; $display("FAIL fixed_dack_idle got %b want 1111", DACK); end
    xfer_window();
    tests_run++; if (DACK !== 4'b1101) begin fails++; $display("FAIL fixed_dack1 got %b want 1101", DACK); end
    xfer_finish();
    tests_run++; if (tcif.valid_dreq !== 4'b0 || tcif.busy !== 1'b1) begin fails++; $display("FAIL fixed_release got vdreq=%b busy=%b want 0000/1", tcif.valid_dreq, tcif.busy); end
    wait_grant();
    tests_run++; if (tcif.valid_dreq !== 4'b1000 || tcif.active_chan !== 2'd3) begin fails++; $display("FAIL fixed_second got %b/%0d want 1000/3", tcif.valid_dreq, tcif.active_chan); end
    xfer_window();
    tests_run++; if (DACK !== 4'b0111) begin fails++; $display("FAIL fixed_dack3 got %b want 0111", DACK); end
    DREQ = 4'b0;
    xfer_finish();
    wait_idle();
    tests_run++; if (tcif.busy !== 1'b0) begin fails++; $display("FAIL fixed_idle got busy=%b want 0", tcif.busy); end
  endtask

  task automatic test_rotating();
    logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    command_reg = 8'h10; DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant();
      tests_run++; if (tcif.active_chan !== exp_ch[i] || tcif.valid_dreq !== (4'b0001 << exp_ch[i])) begin
        fails++; $display("FAIL rotate_%0d got %0d/%b want %0d", i, tcif.active_chan, tcif.valid_dreq, exp_ch[i]);
      end
      if (i == 4) DREQ = 4'b0;
      xfer_window();
      xfer_finish();
    end
    wait_idle();
    command_reg = 8'h00;
  endtask

  task automatic test_block_eop();
    mode_reg = CH2_BLOCK; DREQ = 4'b0100;
    wait_grant();
    tests_run++; if (tcif.valid_dreq !== 4'b0100) begin fails++; $display("FAIL block_grant got %b want 0100", tcif.valid_dreq); end
    for (int i = 0; i < 3; i++) begin
      tcif.xfer_done = 1'b1; step(); tcif.xfer_done = 1'b0; step();
      tests_run++; if (tcif.valid_dreq !== 4'b0100) begin fails++; $display("FAIL block_hold_%0d got %b want 0100", i, tcif.valid_dreq); end
    end
    DREQ = 4'b0; tcif.EOP_N = 1'b0; step(); tcif.EOP_N = 1'b1;
    tests_run++; if (mask_set !== 4'b0100 || tcif.valid_dreq !== 4'b0) begin fails++; $display("FAIL block_eop got mask_set=%b vdreq=%b want 0100/0000", mask_set, tcif.valid_dreq); end
    step();
    tests_run++; if (mask_set !== 4'b0) begin fails++; $display("FAIL block_mask_pulse got %b want 0000", mask_set); end
    wait_idle();
    mode_reg = ALL_SINGLE;
  endtask

  task automatic test_software();
    req_reg = 4'b0001;
    wait_grant();
    tests_run++; if (tcif.valid_dreq !== 4'b0001) begin fails++; $display("FAIL sw_grant got %b want 0001", tcif.valid_dreq); end
    xfer_window();
    xfer_finish();
    tests_run++; if (req_clr !== 4'b0001) begin fails++; $display("FAIL sw_req_clr got %b want 0001", req_clr); end
    tests_run++; if (mask_set !== 4'b0) begin fails++; $display("FAIL sw_no_mask got %b want 0000", mask_set); end
    req_reg = 4'b0; step();
    tests_run++; if (req_clr !== 4'b0) begin fails++; $display("FAIL sw_clr_pulse got %b want 0000", req_clr); end
    wait_idle();
    mask_reg = 4'b0001; req_reg = 4'b0001;
    repeat (6) step();
    tests_run++; if (tcif.valid_dreq !== 4'b0 || tcif.busy !== 1'b0) begin fails++; $display("FAIL sw_masked got %b/%b want 0000/0", tcif.valid_dreq, tcif.busy); end
    req_reg = 4'b0; mask_reg = 4'b0;
  endtask

  task automatic test_polarity();
    mask_reg = 4'b1111; command_reg = 8'hC0; DREQ = 4'b1011;
    repeat (4) step();
    tests_run++; if (DACK !== 4'b0000) begin fails++; $display("FAIL pol_dack_idle got %b want 0000", DACK); end
    mask_reg = 4'b0;
    wait_grant();
    tests_run++; if (tcif.valid_dreq !== 4'b0100) begin fails++; $display("FAIL pol_grant got %b want 0100", tcif.valid_dreq); end
    DREQ = 4'b1111;
    xfer_window();
    tests_run++; if (DACK !== 4'b0100) begin fails++; $display("FAIL pol_dack_on got %b want 0100", DACK); end
    xfer_finish();
    wait_idle();
    tests_run++; if (DACK !== 4'b0000) begin fails++; $display("FAIL pol_dack_off got %b want 0000", DACK); end
    mask_reg = 4'b1111; DREQ = 4'b0;
    repeat (3) step();
    command_reg = 8'h00; step(); mask_reg = 4'b0;
  endtask

  task automatic test_async_reset();
    DREQ = 4'b0100;
    wait_grant();
    tests_run++; if (tcif.valid_dreq !== 4'b0100) begin fails++; $display("FAIL ar_pre got %b want 0100", tcif.valid_dreq); end
    #2 RESET_N = 1'b0;
    #1;
    tests_run++; if (tcif.valid_dreq !== 4'b0 || DACK !== 4'b1111 || tcif.busy !== 1'b0) begin
      fails++; $display("FAIL ar_immediate got vdreq=%b dack=%b busy=%b want 0000/1111/0", tcif.valid_dreq, DACK, tcif.busy);
    end
    step(); step();
    command_reg = 8'h10; DREQ = 4'b1111; RESET_N = 1'b1;
    wait_grant();
    tests_run++; if (tcif.valid_dreq !== 4'b0001 || tcif.active_chan !== 2'd0) begin fails++; $display("FAIL ar_first got %b/%0d want 0001/0", tcif.valid_dreq, tcif.active_chan); end
    DREQ = 4'b0;
    xfer_window();
    xfer_finish();
    wait_idle();
    command_reg = 8'h00;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotating();
    test_block_eop();
    test_software();
    test_polarity();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Request-resolution stage directly upstream of the DMA timing control.
- Synchronises and qualifies the four DREQ lines and software requests, and resolves priority (fixed or rotating).
- Presents one one-hot valid_dreq vector to the timing control and holds it for the service duration per channel mode.
- Drives the polarity-corrected DACK pins, and issues pulses that clear request bits and set mask bits on completion.

Parameters:
- NCH, 4, number of channels; the logic is written for 4; other values are unsupported.
- SYNC_STAGES, 2, DREQ synchroniser depth in flops (≥1).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- DREQ  input  4  peripheral requests; asynchronous; sense selected by command_reg[6].
- HLDA  input  1  hold acknowledge from the CPU.
- command_reg  input  8  [2]=controller disable, [4]=rotating priority, [6]=DREQ active-low, [7]=DACK active-high.
- mode_reg  input  24  per channel ch, bits [6ch+5:6ch] = mode byte [7:2]: [5:4] mode (00 demand, 01 single, 10 block, 11 cascade), [2] autoinit.
- mask_reg  input  4  1 = channel masked.
- req_reg  input  4  software request bits.
- valid_dack  input  1  timing control is in the transfer window (S1..S3).
- xfer_done  input  1  one-cycle pulse: one transfer completed (timing control S4).
- EOP_N  input  1  end of process, active-low, synchronous to CLK.
- valid_dreq  output  4  one-hot granted channel to the timing control.
- DACK  output  4  acknowledge pins, polarity per command_reg[7].
- active_chan  output  2  channel being serviced.
- busy  output  1  arbiter is not IDLE.
- req_clr  output  4  one-cycle pulse: clear the software request bit.
- mask_set  output  4  one-cycle pulse: set the mask bit (EOP without autoinit).

Behaviour:
- Reset values (async on RESET_N low):
  - valid_dreq=0, active_chan=0, busy=0, req_clr=0, mask_set=0.
  - DACK=4'b1111 (inactive for the reset DACK sense, active-low).
  - Priority pointer=0; synchroniser flops cleared; state=IDLE.
- Synchroniser: DREQ passes SYNC_STAGES flops. Sensed request: hw[i] = sync[i] ^ command_reg[6].
- Pending vector: pend = (hw | req_reg) & ~mask_reg. It is forced to 0 when command_reg[2]=1.
- Priority:
  - Fixed mode (cmd[4]=0): channel 0 highest, channel 3 lowest.
  - Rotating mode (cmd[4]=1): pointer channel is highest, then ascending modulo 4.
  - After any service ends, pointer = (serviced channel + 1) mod 4. The pointer updates in fixed mode too but is ignored there.
- State machine:
  - IDLE: if pend≠0 → ARB.
  - ARB (1 cycle): latch winner into active_chan and the latched mode; set valid_dreq one-hot → GRANT. If pend became 0 in this cycle → IDLE, with no grant.
  - GRANT: valid_dreq is held. Exits by mode:
    - Single: xfer_done → RELEASE.
    - Demand: xfer_done with the channel request deasserted → RELEASE; otherwise stay.
    - Block: stay until EOP_N=0.
    - Cascade: stay until the channel request deasserts; DACK tracks HLDA instead of valid_dack.
  - EOP_N=0 in GRANT (any mode except cascade) → RELEASE. It takes priority over every other exit.
  - Mask set after grant does not abort the current transfer; it is evaluated at the next xfer_done and forces RELEASE.
  - RELEASE (1 cycle):
    - valid_dreq=0; update pointer.
    - Pulse req_clr[chan] if req_reg[chan]=1.
    - Pulse mask_set[chan] if exit was by EOP and autoinit=0.
    - → IDLE.
- Minimum re-grant latency after RELEASE: 2 cycles (IDLE → ARB → grant).
- DACK (registered):
  - Asserted for active_chan while state=GRANT and valid_dack=1 (cascade: HLDA=1).
  - Asserted level = command_reg[7]; all other bits take the inactive level.
- command_reg[2] set during GRANT: the current service completes normally; no new grants follow.
- Simultaneous new request and RELEASE: the new request is arbitrated with the updated pointer.
- busy=1 in ARB, GRANT and RELEASE.

Test Plan:
- Fixed priority: DREQ=4'b1010 together, cmd=0, all single mode → grant ch1, one xfer_done, release; next grant ch3; DACK[1] then DACK[3] low only during valid_dack.
- Rotating priority: cmd[4]=1, DREQ held 4'b1111, single mode → grant order 0,1,2,3,0; pointer wraps from 3 to 0.
- Block mode ch2 with 3 xfer_done pulses and no EOP → valid_dreq=4'b0100 held. Then EOP_N=0 with autoinit=0 → mask_set=4'b0100 for exactly 1 cycle.
- Software request: req_reg=4'b0001, DREQ idle → grant ch0; after xfer_done, req_clr=4'b0001 for 1 cycle. With mask_reg[0]=1 → no grant.
- Polarity: cmd[6]=1, cmd[7]=1, DREQ[2] driven low → grant ch2; DACK=4'b0100 during valid_dack, 4'b0000 otherwise.
- Async reset: assert RESET_N low mid-GRANT without a clock edge → valid_dreq=0, DACK=1111, busy=0 immediately; first grant after release is ch0.
